// File: rtl/axicb_pkg.sv
// axicb_pkg: FSM encoding and width helpers shared by the read outstanding controller.
package axicb_pkg;

    typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, DRAINED = 2'd2} state_e;

    function automatic int cnt_w(input int ostd_max);
        return $clog2(ostd_max + 1);
    endfunction

    function automatic int tmr_w(input int cycles);
        return $clog2(cycles);
    endfunction

endpackage

// File: rtl/axicb_ostd_counter.sv
// axicb_ostd_counter: per-master outstanding read count, pending-AR flag and response timeout.
module axicb_ostd_counter
    import axicb_pkg::*;
#(
    parameter int OSTD_MAX       = 4,
    parameter int TIMEOUT_ENABLE = 1,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic aclk,
    input  logic arst,
    input  logic srst,
    input  logic s_arvalid,
    input  logic s_arready,
    input  logic r_valid,
    input  logic r_ready,
    input  logic r_last,
    input  logic tmo_clr,
    output logic pend,
    output logic full,
    output logic busy,
    output logic idle_nxt,
    output logic err
);

    localparam int CNT_W = cnt_w(OSTD_MAX);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(OSTD_MAX);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic pend_q, pend_d, ar_hs, r_done;

    always_comb begin
        ar_hs  = s_arvalid & s_arready;
        r_done = r_valid & r_ready & r_last;
        cnt_d  = (ar_hs && !r_done) ? cnt_q + 1'b1 :
                 (r_done && !ar_hs && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
        pend_d = !ar_hs && (s_arvalid || pend_q);
    end

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            cnt_q  <= '0;
            pend_q <= 1'b0;
        end else if (srst) begin
            cnt_q  <= '0;
            pend_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
        end
    end

    assign pend     = pend_q;
    assign full     = cnt_q == CNT_MAX;
    assign busy     = cnt_q != '0;
    // Drain completion looks at next-state so drain_done rises the cycle after the last completion
    assign idle_nxt = cnt_d == '0 && !pend_d;

    generate
        if (TIMEOUT_ENABLE != 0) begin : g_tmo
            localparam int TMR_W = tmr_w(TIMEOUT_CYCLES);
            localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT_CYCLES - 1);
            logic [TMR_W-1:0] tmr_q, tmr_d;
            logic err_q, err_d;
            always_comb begin
                tmr_d = (cnt_q == '0 || (r_valid && r_ready)) ? '0 :
                        (tmr_q == TMR_MAX) ? tmr_q : tmr_q + 1'b1;
                err_d = !tmo_clr && (err_q || tmr_d == TMR_MAX);
            end
            always_ff @(posedge aclk or posedge arst) begin
                if (arst) begin
                    tmr_q <= '0;
                    err_q <= 1'b0;
                end else if (srst) begin
                    tmr_q <= '0;
                    err_q <= 1'b0;
                end else begin
                    tmr_q <= tmr_d;
                    err_q <= err_d;
                end
            end
            assign err = err_q;
        end else begin : g_no_tmo
            assign err = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/axicb_rd_ostd_ctrl.sv
// axicb_rd_ostd_ctrl: gates per-master AR requests on outstanding-read limits and sequences read drain.
module axicb_rd_ostd_ctrl
    import axicb_pkg::*;
#(
    parameter int MST_NB         = 4,
    parameter int OSTD_MAX       = 4,
    parameter int TIMEOUT_ENABLE = 1,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              aclk,
    input  logic              arst,
    input  logic              srst,
    input  logic [MST_NB-1:0] m_arvalid,
    output logic [MST_NB-1:0] m_arready,
    output logic [MST_NB-1:0] s_arvalid,
    input  logic [MST_NB-1:0] s_arready,
    input  logic [MST_NB-1:0] r_valid,
    input  logic [MST_NB-1:0] r_ready,
    input  logic [MST_NB-1:0] r_last,
    input  logic              drain_req,
    output logic              drain_done,
    output logic [MST_NB-1:0] ostd_busy,
    input  logic              tmo_clr,
    output logic [MST_NB-1:0] timeout_err
);

    state_e state_q, state_d;
    logic drain_done_q, drain_done_d;
    logic [MST_NB-1:0] pend, full, idle_nxt, pass;

    // A pending AR is never withdrawn, whatever the limit or drain state says
    always_comb begin
        pass         = pend | ~(full | {MST_NB{state_q != RUN}}) | {MST_NB{srst}};
        s_arvalid    = m_arvalid & pass;
        m_arready    = s_arready & pass;
        state_d      = !drain_req ? RUN :
                       (state_q == RUN) ? DRAIN :
                       (state_q == DRAIN && &idle_nxt) ? DRAINED : state_q;
        drain_done_d = state_d == DRAINED;
    end

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            state_q      <= RUN;
            drain_done_q <= 1'b0;
        end else if (srst) begin
            state_q      <= RUN;
            drain_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            drain_done_q <= drain_done_d;
        end
    end

    assign drain_done = drain_done_q;

    for (genvar i = 0; i < MST_NB; i++) begin : g_mst
        axicb_ostd_counter #(
            .OSTD_MAX       (OSTD_MAX),
            .TIMEOUT_ENABLE (TIMEOUT_ENABLE),
            .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
        ) u_cnt (
            .aclk      (aclk),
            .arst      (arst),
            .srst      (srst),
            .s_arvalid (s_arvalid[i]),
            .s_arready (s_arready[i]),
            .r_valid   (r_valid[i]),
            .r_ready   (r_ready[i]),
            .r_last    (r_last[i]),
            .tmo_clr   (tmo_clr),
            .pend      (pend[i]),
            .full      (full[i]),
            .busy      (ostd_busy[i]),
            .idle_nxt  (idle_nxt[i]),
            .err       (timeout_err[i])
        );
    end

endmodule

// File: tb/tb_axicb_rd_ostd_ctrl.sv
// tb_axicb_rd_ostd_ctrl: directed checks of AR gating, drain, timeout and reset, plus a randomized limit run.
module tb_axicb_rd_ostd_ctrl;

    logic aclk = 1'b0, arst = 1'b1, srst = 1'b0, drain_req = 1'b0, tmo_clr = 1'b0;
    logic [3:0] m_arvalid = '0, s_arready = '0, r_valid = '0, r_ready = '0, r_last = '0;
    logic [3:0] m_arready, s_arvalid, ostd_busy, timeout_err;
    logic drain_done;
    logic [3:0] b_m_arvalid = '0, b_s_arready = '0, b_r_valid = '0, b_r_ready = '0, b_r_last = '0;
    logic [3:0] b_m_arready, b_s_arvalid, b_ostd_busy, b_timeout_err;
    logic b_drain_done;
    int vecs = 0, errs = 0;
    int mcnt [4];
    bit mpend [4], hold [4];
    logic [3:0] exp_sv, exp_ar, pass_m;

    always #5 aclk = ~aclk;

    axicb_rd_ostd_ctrl #(.MST_NB(4), .OSTD_MAX(2), .TIMEOUT_ENABLE(1), .TIMEOUT_CYCLES(16)) dut (
        .aclk(aclk), .arst(arst), .srst(srst),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .r_valid(r_valid), .r_ready(r_ready), .r_last(r_last),
        .drain_req(drain_req), .drain_done(drain_done), .ostd_busy(ostd_busy),
        .tmo_clr(tmo_clr), .timeout_err(timeout_err)
    );

    axicb_rd_ostd_ctrl #(.MST_NB(4), .OSTD_MAX(4), .TIMEOUT_ENABLE(1), .TIMEOUT_CYCLES(256)) dut_b (
        .aclk(aclk), .arst(arst), .srst(srst),
        .m_arvalid(b_m_arvalid), .m_arready(b_m_arready), .s_arvalid(b_s_arvalid), .s_arready(b_s_arready),
        .r_valid(b_r_valid), .r_ready(b_r_ready), .r_last(b_r_last),
        .drain_req(drain_req), .drain_done(b_drain_done), .ostd_busy(b_ostd_busy),
        .tmo_clr(tmo_clr), .timeout_err(b_timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge aclk);
        #1;
    endtask

    task automatic rd(input logic [3:0] v);
        r_valid = v;
        r_ready = v;
        r_last  = v;
    endtask

    initial begin
        cyc();
        m_arvalid = 4'b0101; s_arready = 4'b0001; #1;
        chk("rst_busy", ostd_busy, 0);
        chk("rst_err", timeout_err, 0);
        chk("rst_done", drain_done, 0);
        chk("rst_s_arvalid", s_arvalid, 4'b0101);
        chk("rst_m_arready", m_arready, 4'b0001);
        m_arvalid = '0;
        cyc(); arst = 1'b0;

        // limit of 2: third AR waits for a completion
        m_arvalid = 4'b0001; s_arready = 4'b0011; #1;
        chk("t1_sv_a", s_arvalid[0], 1);
        chk("t1_ar_a", m_arready[0], 1);
        cyc(); #1;
        chk("t1_busy", ostd_busy[0], 1);
        chk("t1_sv_b", s_arvalid[0], 1);
        cyc(); #1;
        chk("t1_ar_full", m_arready[0], 0);
        chk("t1_sv_full", s_arvalid[0], 0);
        rd(4'b0001); #1;
        chk("t1_ar_full_rdone", m_arready[0], 0);
        cyc(); rd('0); #1;
        chk("t1_ar_reopen", m_arready[0], 1);
        chk("t1_sv_reopen", s_arvalid[0], 1);
        cyc(); m_arvalid = '0; #1;
        chk("t1_ar_full2", m_arready[0], 0);

        // simultaneous handshake and completion at cnt=1
        rd(4'b0001); cyc();
        m_arvalid[0] = 1'b1; #1;
        chk("t2_sv", s_arvalid[0], 1);
        cyc(); m_arvalid = '0; rd('0); #1;
        chk("t2_busy", ostd_busy[0], 1);
        chk("t2_ar_open", m_arready[0], 1);
        rd(4'b0001); cyc(); rd('0); #1;
        chk("t2_idle", ostd_busy[0], 0);

        // drain with an AR pending when drain_req rises
        s_arready[0] = 1'b0; m_arvalid[0] = 1'b1; #1;
        chk("t3_sv_wait", s_arvalid[0], 1);
        chk("t3_ar_wait", m_arready[0], 0);
        cyc(); drain_req = 1'b1; #1;
        chk("t3_sv_hold0", s_arvalid[0], 1);
        cyc(); m_arvalid[1] = 1'b1; #1;
        chk("t3_sv_hold1", s_arvalid[0], 1);
        chk("t3_sv1_gated", s_arvalid[1], 0);
        chk("t3_ar1_gated", m_arready[1], 0);
        chk("t3_done0", drain_done, 0);
        s_arready[0] = 1'b1; #1;
        chk("t3_ar_hs", m_arready[0], 1);
        cyc(); m_arvalid[0] = 1'b0; #1;
        chk("t3_busy", ostd_busy[0], 1);
        chk("t3_done1", drain_done, 0);
        cyc(); #1;
        chk("t3_done2", drain_done, 0);
        rd(4'b0001); cyc(); rd('0); #1;
        chk("t3_done_rise", drain_done, 1);
        chk("t3_sv1_drained", s_arvalid[1], 0);
        drain_req = 1'b0; #1;
        chk("t3_done_hold", drain_done, 1);
        cyc(); #1;
        chk("t3_done_fall", drain_done, 0);
        chk("t3_sv1_run", s_arvalid[1], 1);
        m_arvalid[1] = 1'b0;

        // timeout on master 1 with TIMEOUT_CYCLES=16
        cyc(); m_arvalid[1] = 1'b1;
        cyc(); m_arvalid[1] = 1'b0; #1;
        chk("t4_busy1", ostd_busy[1], 1);
        chk("t4_err0", timeout_err[1], 0);
        repeat (14) cyc();
        #1; chk("t4_err_14", timeout_err[1], 0);
        cyc(); #1;
        chk("t4_err_15", timeout_err[1], 1);
        r_valid[1] = 1'b1; r_ready[1] = 1'b1;
        cyc(); r_valid = '0; r_ready = '0; #1;
        chk("t4_err_sticky", timeout_err[1], 1);
        chk("t4_busy_beat", ostd_busy[1], 1);
        tmo_clr = 1'b1;
        cyc(); tmo_clr = 1'b0; #1;
        chk("t4_err_clr", timeout_err[1], 0);
        repeat (13) cyc();
        #1; chk("t4_err_re13", timeout_err[1], 0);
        cyc(); #1;
        chk("t4_err_re14", timeout_err[1], 1);

        // asynchronous reset mid-burst
        m_arvalid = 4'b0101; s_arready = 4'b0011;
        cyc(); cyc();
        m_arvalid[0] = 1'b0; rd(4'b0001); #1;
        chk("t5_pre_busy", ostd_busy, 4'b0011);
        arst = 1'b1; #1;
        chk("t5_busy", ostd_busy, 0);
        chk("t5_err", timeout_err, 0);
        chk("t5_done", drain_done, 0);
        chk("t5_sv", s_arvalid, 4'b0100);
        rd('0); m_arvalid = '0;
        cyc(); arst = 1'b0;
        cyc(); #1;
        chk("t5_busy_after", ostd_busy, 0);
        chk("t5_ar_open", m_arready, 4'b0011);

        // synchronous clear
        m_arvalid[0] = 1'b1;
        cyc(); m_arvalid[0] = 1'b0; #1;
        chk("t6_busy", ostd_busy[0], 1);
        srst = 1'b1;
        cyc(); srst = 1'b0; #1;
        chk("t6_srst", ostd_busy, 0);

        // randomized traffic on the OSTD_MAX=4 instance
        for (int i = 0; i < 4; i++) begin
            mcnt[i] = 0; mpend[i] = 1'b0; hold[i] = 1'b0;
        end
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!hold[i]) b_m_arvalid[i] = ($urandom_range(0, 9) < 7);
                b_s_arready[i] = 1'($urandom_range(0, 1));
                b_r_valid[i]   = (mcnt[i] > 0) && ($urandom_range(0, 1) == 1);
                b_r_ready[i]   = 1'($urandom_range(0, 3) != 0);
                b_r_last[i]    = 1'($urandom_range(0, 1));
            end
            #1;
            for (int i = 0; i < 4; i++) begin
                pass_m[i] = mpend[i] || mcnt[i] < 4;
                exp_sv[i] = b_m_arvalid[i] & pass_m[i];
                exp_ar[i] = b_s_arready[i] & pass_m[i];
                chk($sformatf("rnd_sv%0d", i), b_s_arvalid[i], exp_sv[i]);
                chk($sformatf("rnd_ar%0d", i), b_m_arready[i], exp_ar[i]);
                hold[i]  = b_m_arvalid[i] & ~exp_ar[i];
                mpend[i] = exp_sv[i] & ~b_s_arready[i];
                if ((exp_sv[i] & b_s_arready[i]) && !(b_r_valid[i] & b_r_ready[i] & b_r_last[i]))
                    mcnt[i]++;
                else if (!(exp_sv[i] & b_s_arready[i]) && (b_r_valid[i] & b_r_ready[i] & b_r_last[i]) && mcnt[i] > 0)
                    mcnt[i]--;
            end
            cyc();
            for (int i = 0; i < 4; i++)
                chk($sformatf("rnd_busy%0d", i), b_ostd_busy[i], mcnt[i] != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/axicb_rd_ostd_ctrl.md
# axicb_rd_ostd_ctrl

Per-master read outstanding-transaction controller that sits between the masters' AR channels and the read master switch. It counts in-flight read bursts per master and gates new AR requests once a master reaches its limit. It watches the per-master R channel for burst completion and per-master response timeout. It also offers a drain sequence that quiesces all read traffic before reconfiguration or soft reset.

## Interface
Parameters:
- MST_NB, 4: number of masters (1..4)
- OSTD_MAX, 4: max outstanding read bursts per master (>=1); counter width CNT_W = $clog2(OSTD_MAX+1)
- TIMEOUT_ENABLE, 1: 1 = per-master response timers present; 0 = timers removed, timeout_err tied 0
- TIMEOUT_CYCLES, 256: idle cycles with outstanding reads before timeout (>=2); timer width $clog2(TIMEOUT_CYCLES)

Ports:
- aclk  in  1  clock
- arst  in  1  reset, asynchronous and active-high
- srst  in  1  synchronous clear, same effect as arst
- m_arvalid  in  MST_NB  AR valid from masters
- m_arready  out  MST_NB  AR ready to masters
- s_arvalid  out  MST_NB  AR valid to switch
- s_arready  in  MST_NB  AR ready from switch
- r_valid  in  MST_NB  per-master R valid (switch side, monitor only)
- r_ready  in  MST_NB  per-master R ready (master side, monitor only)
- r_last  in  MST_NB  per-master R last (monitor only)
- drain_req  in  1  level request to quiesce reads
- drain_done  out  1  all masters idle, AR blocked
- ostd_busy  out  MST_NB  cnt[i] != 0
- tmo_clr  in  1  clears all timeout_err bits
- timeout_err  out  MST_NB  sticky response timeout per master

## Operation
- ar_hs[i] = s_arvalid[i] & s_arready[i]; r_done[i] = r_valid[i] & r_ready[i] & r_last[i].
- cnt[i]: +1 on ar_hs only, -1 on r_done only, unchanged on both. A decrement at 0 saturates at 0.
- pend[i]: set when s_arvalid[i] & ~s_arready[i]; cleared on ar_hs[i]. Guarantees AXI valid stability: while pend[i]=1, block[i] is ignored.
- block[i] = (cnt[i]==OSTD_MAX) | (state != RUN).
- s_arvalid[i] = m_arvalid[i] & (pend[i] | ~block[i]); m_arready[i] = s_arready[i] & (pend[i] | ~block[i]).
- FSM (state reset = RUN):
  - RUN -> DRAIN when drain_req=1.
  - DRAIN -> RUN when drain_req=0.
  - DRAIN -> DRAINED when all cnt==0 and all pend==0.
  - DRAINED -> RUN when drain_req=0.
- drain_done = (state==DRAINED), registered.
- Timer[i] (TIMEOUT_ENABLE=1): cleared when cnt[i]==0 or on any r_valid[i]&r_ready[i] beat; otherwise increments.
  - When timer[i] reaches TIMEOUT_CYCLES-1, set timeout_err[i] and hold timer there (saturate).
  - tmo_clr clears all err bits and takes priority over a same-cycle set.

## Timing
- AR gating is combinational, zero latency; no AR payload passes through this block.
- Counter, pend, timer and FSM update on the aclk edge after the event. The handshake that brings cnt to OSTD_MAX blocks that master from the next cycle.
- drain_done rises 1 cycle after the last r_done or ar_hs clears the final condition. It falls 1 cycle after drain_req drops.
- Reset (arst async or srst sync): cnt=0, pend=0, timers=0, timeout_err=0, state=RUN, drain_done=0, ostd_busy=0. Combinational outputs follow inputs with block=0.
- An AR pending when drain_req rises completes normally and is counted. DRAIN then waits for its response.

## Structure
- axicb_pkg holds the FSM typedef enum {RUN, DRAIN, DRAINED} and the width helper constants.
- Sub-module axicb_ostd_counter is instantiated MST_NB times via generate. It contains cnt, pend, timer and err, and outputs block-independent status.
- The top holds the FSM, gating and the drain-done reduction.

## Test plan
- OSTD_MAX=2, master0 issues 3 ARs with s_arready=1: the first 2 handshake. cnt0=2, m_arready0=0 and s_arvalid0=0 on the 3rd. After one r_done0, the 3rd handshakes the next cycle.
- Same cycle ar_hs0 and r_done0 with cnt0=1: cnt0 stays 1 and ostd_busy0 stays 1.
- s_arready0=0 with m_arvalid0=1, then drain_req=1: s_arvalid0 stays 1 until s_arready0=1. cnt0 becomes 1. drain_done is asserted 1 cycle after r_done0. drain_req=0 returns to RUN the next cycle.
- TIMEOUT_CYCLES=16, cnt1=1, no R beats: timeout_err1=1 after 15 cycles. A beat resets the timer but not the error. tmo_clr clears the error.
- arst asserted mid-burst with cnt=3: all counters, pend, errors and drain_done are 0 immediately. No false r_done decrement occurs after release.
- Four masters each at OSTD_MAX=4 with random R completion: every master's cnt never exceeds 4 and never goes below 0. s_arvalid never drops without a handshake.
